// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and forwarding controller for the 5-stage pipelined ARM datapath.
// Produces the Fetch/Decode stall and Decode/Execute flush controls together
// with the Execute-stage operand forwarding selects. The controller works from
// the register-address and control tags that travel down the pipeline.
//
// Parameters
//   RA_W       register address width
//   LU_BUBBLES bubbles inserted on a load-use hazard (1..3)
//   FWD_EN     1 = forwarding enabled, 0 = every RAW hazard resolved by stall
//   CNT_W      performance counter width
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   RA1D, RA2D                 Decode source registers
//   RA1E, RA2E                 Execute source registers
//   WA3E, WA3M, WA3W           destination registers in E / M / W
//   RegWriteE/M/W              register write enables per stage
//   LoadE                      Execute instruction reads data memory
//   PCSrcD/E/M/W               instruction in that stage writes R15
//   BranchTakenE               branch resolved taken in Execute
//   perf_clr                   synchronous clear of both perf counters
//   StallF, StallD             hold Fetch / Decode pipeline register
//   FlushD, FlushE             clear Decode / Execute pipeline register
//   ForwardAE, ForwardBE       00 = regfile, 01 = ResultW, 10 = ALUResultM
//   lu_busy                    multi-cycle load-use sequence in progress
//   stall_cnt, flush_cnt       saturating StallF / BranchTakenE cycle counts
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int RA_W       = 4,
  parameter int LU_BUBBLES = 1,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  RA1E,
  input  logic [RA_W-1:0]  RA2E,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             perf_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             lu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // R15 is the PC; it is never forwarded and never creates a RAW hazard.
  localparam logic [RA_W-1:0] PC_REG    = RA_W'(15);
  localparam bit              FWD_ON    = (FWD_EN != 0);
  localparam bit              MULTI_LU  = (LU_BUBBLES > 1);
  localparam logic [1:0]      LU_LOAD   = 2'(LU_BUBBLES - 1);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_W  = 2'b01;
  localparam logic [1:0] SEL_M  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    LU   = 1'b1
  } lu_state_t;

  lu_state_t  state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // ---------------------------------------------------------------------------
  // Forwarding selects, one per Execute operand side (0 = A, 1 = B)
  // ---------------------------------------------------------------------------
  logic [RA_W-1:0] ra_e [2];
  logic [1:0]      fwd_sel [2];

  assign ra_e[0] = RA1E;
  assign ra_e[1] = RA2E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = SEL_RF;
        if (FWD_ON && (ra_e[gi] != PC_REG)) begin
          // Memory stage holds the younger result, so it wins over Writeback.
          if (RegWriteM && (WA3M == ra_e[gi]))
            fwd_sel[gi] = SEL_M;
          else if (RegWriteW && (WA3W == ra_e[gi]))
            fwd_sel[gi] = SEL_W;
        end
      end
    end
  endgenerate

  assign ForwardAE = fwd_sel[0];
  assign ForwardBE = fwd_sel[1];

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic [RA_W-1:0] ra_d [2];
  logic [1:0]      raw_src;
  logic            ldr_hit;
  logic            raw_hit;
  logic            hazard;
  logic            pc_pend;
  logic            lu_stall;

  assign ra_d[0] = RA1D;
  assign ra_d[1] = RA2D;

  assign ldr_hit = LoadE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // Without forwarding any in-flight writer of a Decode source must drain
  // before the instruction may leave Decode.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_raw
      assign raw_src[gi] = (ra_d[gi] != PC_REG) &
                           ((RegWriteE & (WA3E == ra_d[gi])) |
                            (RegWriteM & (WA3M == ra_d[gi])) |
                            (RegWriteW & (WA3W == ra_d[gi])));
    end
  endgenerate

  assign raw_hit = |raw_src;
  assign hazard  = FWD_ON ? ldr_hit : raw_hit;
  assign pc_pend = PCSrcD | PCSrcE | PCSrcM;

  // ---------------------------------------------------------------------------
  // Load-use sequencer. The first bubble comes straight from the hazard in
  // IDLE; LU only covers the additional bubbles for slower data memories.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        // The counted sequence only exists with forwarding; the stall-only
        // mode is purely combinational.
        if (FWD_ON && MULTI_LU && ldr_hit && !BranchTakenE) begin
          state_next = LU;
          cnt_next   = LU_LOAD;
        end
      end
      LU: begin
        cnt_next = cnt_reg - 2'd1;
        // A taken branch kills the Decode instruction, so the remaining
        // bubbles are pointless.
        if ((cnt_reg == 2'd1) || BranchTakenE) begin
          state_next = IDLE;
          cnt_next   = 2'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  assign lu_stall = ((state_reg == IDLE) & hazard) | (state_reg == LU);
  assign lu_busy  = (state_reg == LU);

  // ---------------------------------------------------------------------------
  // Pipeline controls. A taken branch overrides the Decode hold: that
  // instruction is wrong-path and gets flushed instead.
  // ---------------------------------------------------------------------------
  assign StallF = lu_stall | pc_pend;
  assign StallD = lu_stall & ~BranchTakenE;
  assign FlushD = pc_pend | PCSrcW | BranchTakenE;
  assign FlushE = lu_stall | BranchTakenE;

  // ---------------------------------------------------------------------------
  // Saturating performance counters; clear beats increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (perf_clr) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallF && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (BranchTakenE && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. Three instances share the inputs:
//   dut    LU_BUBBLES=3, forwarding on,  CNT_W=4
//   dut1   LU_BUBBLES=1, forwarding on,  CNT_W=16
//   dutnf  LU_BUBBLES=1, forwarding off, CNT_W=4
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit
// later, well clear of either clock edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, LoadE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, perf_clr;

  logic       StallF, StallD, FlushD, FlushE, lu_busy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cnt, flush_cnt;

  logic        StallF1, StallD1, FlushD1, FlushE1, lu_busy1;
  logic [1:0]  ForwardAE1, ForwardBE1;
  logic [15:0] stall_cnt1, flush_cnt1;

  logic       StallFn, StallDn, FlushDn, FlushEn, lu_busyn;
  logic [1:0] ForwardAEn, ForwardBEn;
  logic [3:0] stall_cntn, flush_cntn;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RA_W(4), .LU_BUBBLES(3), .FWD_EN(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .perf_clr(perf_clr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .lu_busy(lu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.RA_W(4), .LU_BUBBLES(1), .FWD_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .perf_clr(perf_clr),
    .StallF(StallF1), .StallD(StallD1), .FlushD(FlushD1), .FlushE(FlushE1),
    .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1), .lu_busy(lu_busy1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  pipeline_hazard_ctrl #(.RA_W(4), .LU_BUBBLES(1), .FWD_EN(0), .CNT_W(4)) dutnf (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .perf_clr(perf_clr),
    .StallF(StallFn), .StallD(StallDn), .FlushD(FlushDn), .FlushE(FlushEn),
    .ForwardAE(ForwardAEn), .ForwardBE(ForwardBEn), .lu_busy(lu_busyn),
    .stall_cnt(stall_cntn), .flush_cnt(flush_cntn)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
    WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; LoadE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; perf_clr = 0;
  endtask

  task automatic load_use_hit();
    LoadE = 1; RegWriteE = 1; WA3E = 4'd5; RA2D = 4'd5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pc_stall_exp [5];
    logic [1:0] pc_flush_exp [5];

    clear_inputs();
    reset = 1;
    #3;
    check_val("rst_stall_cnt", stall_cnt, 0);
    check_val("rst_flush_cnt", flush_cnt, 0);
    check_val("rst_lu_busy", lu_busy, 0);
    check_val("rst_StallF", StallF, 0);
    step();
    reset = 0;
    step();

    // ---------------- forwarding priority ----------------
    RA1E = 3; WA3M = 3; WA3W = 3; RegWriteM = 1; RegWriteW = 1;
    #1;
    check_val("fwdA_M", ForwardAE, 2'b10);
    check_val("fwdB_none", ForwardBE, 2'b00);
    check_val("nf_fwdA_off", ForwardAEn, 2'b00);
    RegWriteM = 0;
    #1;
    check_val("fwdA_W", ForwardAE, 2'b01);
    RA2E = 3;
    #1;
    check_val("fwdB_W", ForwardBE, 2'b01);
    RegWriteM = 1; RA1E = 15; WA3M = 15; WA3W = 15;
    #1;
    check_val("fwdA_r15", ForwardAE, 2'b00);
    clear_inputs();
    step();

    // ---------------- load-use, 3 bubbles ----------------
    load_use_hit();
    #1;
    check_val("lu1_StallF", StallF, 1);
    check_val("lu1_StallD", StallD, 1);
    check_val("lu1_FlushE", FlushE, 1);
    check_val("lu1_busy", lu_busy, 0);
    check_val("lu1_dut1_StallF", StallF1, 1);
    step();
    clear_inputs();
    #1;
    check_val("lu2_StallF", StallF, 1);
    check_val("lu2_StallD", StallD, 1);
    check_val("lu2_FlushE", FlushE, 1);
    check_val("lu2_busy", lu_busy, 1);
    check_val("lu2_dut1_StallF", StallF1, 0);
    check_val("lu2_dut1_busy", lu_busy1, 0);
    step();
    #1;
    check_val("lu3_StallD", StallD, 1);
    check_val("lu3_FlushE", FlushE, 1);
    check_val("lu3_busy", lu_busy, 1);
    step();
    #1;
    check_val("lu4_StallF", StallF, 0);
    check_val("lu4_FlushE", FlushE, 0);
    check_val("lu4_busy", lu_busy, 0);

    // ---------------- branch during load-use ----------------
    step();
    load_use_hit();
    step();
    clear_inputs();
    BranchTakenE = 1;
    #1;
    check_val("br_StallD", StallD, 0);
    check_val("br_FlushD", FlushD, 1);
    check_val("br_FlushE", FlushE, 1);
    check_val("br_busy", lu_busy, 1);
    step();
    BranchTakenE = 0;
    #1;
    check_val("br_next_busy", lu_busy, 0);
    check_val("br_next_StallF", StallF, 0);
    check_val("br_next_FlushE", FlushE, 0);

    // ---------------- PC write propagating D->E->M->W ----------------
    pc_stall_exp = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    pc_flush_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    step();
    for (int i = 0; i < 5; i++) begin
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3);
      #1;
      check_val($sformatf("pc%0d_StallF", i), StallF, pc_stall_exp[i]);
      check_val($sformatf("pc%0d_FlushD", i), FlushD, pc_flush_exp[i]);
      step();
    end
    clear_inputs();

    // ---------------- forwarding disabled ----------------
    WA3W = 2; RegWriteW = 1; RA1D = 2; RA1E = 2;
    #1;
    check_val("nf_StallF", StallFn, 1);
    check_val("nf_StallD", StallDn, 1);
    check_val("nf_FlushE", FlushEn, 1);
    check_val("nf_ForwardAE", ForwardAEn, 2'b00);
    check_val("fw_StallF", StallF, 0);
    check_val("fw_ForwardAE", ForwardAE, 2'b01);
    RA1D = 15; WA3W = 15; RA1E = 0;
    #1;
    check_val("nf_r15_StallF", StallFn, 0);
    clear_inputs();
    step();

    // ---------------- counters ----------------
    perf_clr = 1;
    step();
    perf_clr = 0;
    #1;
    check_val("cnt_clr_stall", stall_cnt, 0);
    check_val("cnt_clr_flush", flush_cnt, 0);
    PCSrcD = 1; BranchTakenE = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) BranchTakenE = 0;
      step();
      if (i == 9) check_val("cnt_stall_10", stall_cnt, 10);
    end
    check_val("cnt_stall_sat", stall_cnt, 15);
    check_val("cnt_flush_3", flush_cnt, 3);
    check_val("cnt_dut1_stall_20", stall_cnt1, 20);
    perf_clr = 1;
    #1;
    check_val("cnt_pre_clr_StallF", StallF, 1);
    step();
    perf_clr = 0; PCSrcD = 0;
    #1;
    check_val("cnt_clr_prio_stall", stall_cnt, 0);
    check_val("cnt_clr_prio_flush", flush_cnt, 0);

    // ---------------- asynchronous reset mid-sequence ----------------
    step();
    load_use_hit();
    step();
    clear_inputs();
    #1;
    check_val("ar_busy_before", lu_busy, 1);
    reset = 1;
    #1;
    check_val("ar_busy_now", lu_busy, 0);
    check_val("ar_StallF_now", StallF, 0);
    load_use_hit();
    #1;
    check_val("ar_comb_StallF", StallF, 1);
    step();
    check_val("ar_hold_stall_cnt", stall_cnt, 0);
    check_val("ar_hold_busy", lu_busy, 0);
    clear_inputs();
    #2;
    reset = 0;
    step();
    #1;
    check_val("ar_after_StallF", StallF, 0);
    check_val("ar_after_busy", lu_busy, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
